// File: rtl/wb_regfile_pkg.sv
// Shared widths, load funct3 encodings and the load-fault rule for the
// RV32I write-back stage.
package wb_regfile_pkg;

  localparam int REG_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Major opcode of the I-type load group.
  localparam logic [6:0] INSTR_TYPE_IL = 7'b0000011;

  // Misaligned halfword/word access or an unused load size encoding.
  function automatic logic load_fault(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic f;
    f = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: f = 1'b0;
      F3_LH, F3_LHU: f = addr_lo[0];
      F3_LW:         f = (addr_lo != 2'b00);
      default:       f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/wb_regfile_regfile.sv
// Integer register file: x0 hardwired to zero, one write port, two
// combinational read ports that bypass the value being written this cycle.
module wb_regfile_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN = REG_WIDTH,
  parameter int NREG = 32,
  parameter int AW   = REG_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (we_i && (waddr_i != '0)) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0) rdata1_o = '0;
    else if (we_i && (raddr1_i == waddr_i)) rdata1_o = wdata_i;

    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == '0) rdata2_o = '0;
    else if (we_i && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
  end

endmodule

// File: rtl/wb_regfile.sv
// RV32I write-back stage: MEM/WB pipeline register, load alignment and
// extension, fault detection, and the architectural register file.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN = REG_WIDTH,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            mem_valid_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_regwrite_i,
  input  logic            mem_memtoreg_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [1:0]      mem_addr_lo_i,
  input  logic [XLEN-1:0] mem_alu_result_i,
  input  logic [XLEN-1:0] mem_load_data_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            load_fault_o
);

  logic            valid_q, valid_d;
  logic            regwrite_q, regwrite_d;
  logic            memtoreg_q, memtoreg_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] ldata_q, ldata_d;

  // Flush outranks stall; a flushed slot keeps its payload but can never write.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    alu_d      = alu_q;
    ldata_d    = ldata_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (!stall_i) begin
      valid_d    = mem_valid_i;
      regwrite_d = mem_regwrite_i;
      memtoreg_d = mem_memtoreg_i;
      rd_d       = mem_rd_addr_i;
      funct3_d   = mem_funct3_i;
      addr_lo_d  = mem_addr_lo_i;
      alu_d      = mem_alu_result_i;
      ldata_d    = mem_load_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rd_q       <= '0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      alu_q      <= '0;
      ldata_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      alu_q      <= alu_d;
      ldata_q    <= ldata_d;
    end
  end

  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val;

  always_comb begin
    case (addr_lo_q)
      2'b00:   byte_sel = ldata_q[7:0];
      2'b01:   byte_sel = ldata_q[15:8];
      2'b10:   byte_sel = ldata_q[23:16];
      default: byte_sel = ldata_q[31:24];
    endcase
    half_sel = addr_lo_q[1] ? ldata_q[31:16] : ldata_q[15:0];

    case (funct3_q)
      F3_LB:   load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_val = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_val = {{(XLEN-16){1'b0}}, half_sel};
      default: load_val = ldata_q;
    endcase
  end

  assign wb_data_o    = memtoreg_q ? load_val : alu_q;
  assign load_fault_o = valid_q & memtoreg_q & load_fault(funct3_q, addr_lo_q);
  assign wb_we_o      = valid_q & regwrite_q & (rd_q != 5'd0) & ~load_fault_o;
  assign wb_valid_o   = valid_q;
  assign wb_rd_addr_o = rd_q;

  wb_regfile_regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (5)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_we_o),
    .waddr_i  (rd_q),
    .wdata_i  (wb_data_o),
    .raddr1_i (rs1_addr_i),
    .raddr2_i (rs2_addr_i),
    .rdata1_o (rs1_data_o),
    .rdata2_o (rs2_data_o)
  );

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the RV32I pipeline.
- Registers the MEM/WB control bundle (rd address, regwrite, memtoreg) that the decode stage produced and that travelled down the pipe with its instruction.
- Aligns and sign/zero-extends load data, then writes the 32x32 integer register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass.

Parameters:
- XLEN, 32, data width of registers and datapath.
- NREG, 32, number of architectural registers (x0 hardwired to zero).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold the MEM/WB register
- flush_i  in  1  load a bubble into the MEM/WB register
- mem_valid_i  in  1  MEM stage holds a real instruction
- mem_rd_addr_i  in  5  destination register
- mem_regwrite_i  in  1  instruction writes rd
- mem_memtoreg_i  in  1  1 = result from load data, 0 = from ALU
- mem_funct3_i  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_addr_lo_i  in  2  byte offset of load address
- mem_alu_result_i  in  XLEN  ALU/PC-link result
- mem_load_data_i  in  XLEN  raw aligned word read from data memory
- rs1_addr_i  in  5  decode read port 1 address
- rs2_addr_i  in  5  decode read port 2 address
- rs1_data_o  out  XLEN  read data port 1
- rs2_data_o  out  XLEN  read data port 2
- wb_valid_o  out  1  WB stage holds a real instruction
- wb_we_o  out  1  register-file write enable this cycle
- wb_rd_addr_o  out  5  registered rd
- wb_data_o  out  XLEN  final write-back value
- load_fault_o  out  1  misaligned or illegal-size load in WB this cycle

Behaviour:
- Reset (async, rst_n=0):
  - MEM/WB register cleared: valid=0, regwrite=0, memtoreg=0, rd=0, funct3=0, addr_lo=0, alu=0, ldata=0.
  - All 32 registers cleared to 0.
  - All outputs 0.
  - Reset mid-operation discards the in-flight instruction; no write occurs.
- MEM/WB register, updated at each rising clk:
  - flush_i=1: valid<=0 and regwrite<=0; other fields don't-care. flush has priority over stall.
  - else stall_i=1: all fields hold.
  - else: capture all mem_* inputs.
- Write-back, combinational from the WB register:
  - memtoreg=0: wb_data_o = alu.
  - memtoreg=1: select a byte/half of ldata by addr_lo; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Byte select: addr_lo 00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24].
  - Half select: addr_lo[1]=0 -> [15:0], 1 -> [31:16].
- load_fault_o = valid & memtoreg & fault condition. Fault conditions:
  - LH/LHU with addr_lo[0]=1.
  - LW with addr_lo!=00.
  - funct3 in {011,110,111}.
- wb_we_o = valid & regwrite & (rd!=0) & ~load_fault_o.
- Register file write: regs[rd] <= wb_data_o at rising clk when wb_we_o=1. Latency: the value is architecturally visible one cycle after the instruction enters WB.
- Stall with a valid instruction in WB: the write repeats each stalled cycle. This is idempotent and allowed.
- Read ports, combinational, zero latency:
  - addr=0 -> 0.
  - else if wb_we_o and addr==wb_rd_addr_o -> wb_data_o (bypass).
  - else regs[addr].
  - Both ports are independent; both may bypass in the same cycle.
- x0: never written, always reads 0, even if rd=0 with regwrite=1.

Decomposition:
- Shared package/defines.v holds:
  - REG_WIDTH and REG_ADDR_WIDTH.
  - Load funct3 codes LB/LH/LW/LBU/LHU.
  - INSTR_TYPE_IL opcode, for bench use.
- One natural sub-module: regfile (32xXLEN storage, async reset, one write port, two bypassed read ports).
- Load alignment and fault detection stay in the top level.

Test Plan:
- Reset then read x1..x31 -> all 0; deassert reset, ALU write x5=0x1234_5678 -> next cycle rs1_addr=5 returns 0x1234_5678.
- Same-cycle bypass: WB writes x7=0xDEAD_BEEF while rs1_addr=rs2_addr=7 -> both ports read 0xDEAD_BEEF that cycle.
- Loads with ldata=0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80
  - LBU off=3 -> 0x0000_0080
  - LH off=2 -> 0xFFFF_80FF
  - LHU off=0 -> 0x0000_7F01
  - LW off=0 -> 0x80FF_7F01
- Faults: LW off=01 and LH off=11 -> load_fault_o=1, wb_we_o=0, rd unchanged. funct3=011 -> fault, no write.
- Write to x0 with 0xFFFF_FFFF -> wb_we_o=0, x0 reads 0.
- Control: flush_i with stall_i both 1 -> wb_valid_o=0 next cycle. stall_i alone for 3 cycles -> WB fields held, rd value stable. rst_n low mid-stall -> registers cleared asynchronously, no write.
